// File: rtl/divres_bcd_converter_pkg.sv
// Shared widths, iteration count and FSM state type for the divider-result BCD converter.
package divres_pkg;
  localparam int QW     = 9;
  localparam int RW     = 8;
  localparam int DIGITS = 3;
  localparam int ITER   = QW;
  localparam int BW     = 4 * DIGITS;
  localparam int MW     = QW + 1;
  localparam int CW     = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;
endpackage

// File: rtl/divres_bcd_converter_add3_shift.sv
// One double-dabble step: add 3 to every BCD digit >= 5, then shift {bcd, mag} left by one.
module bcd_add3_shift
  import divres_pkg::*;
(
  input  logic [BW-1:0] bcd,
  input  logic [MW-1:0] mag,
  output logic [BW-1:0] bcd_nxt,
  output logic [MW-1:0] mag_nxt
);

  logic [BW-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    {bcd_nxt, mag_nxt} = {adj, mag} << 1;
  end

endmodule

// File: rtl/divres_bcd_converter.sv
// Converts the signed divider quotient/remainder into sign + packed BCD magnitude.
//   state | meaning
//   IDLE  | waiting for start; results held
//   SHIFT | double-dabble iterations, both lanes in parallel
//   DONE  | one-cycle done pulse; start ignored
module divres_bcd_converter
  import divres_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [QW-1:0] q,
  input  logic [RW-1:0] r,
  output logic          busy,
  output logic          done,
  output logic          q_sign,
  output logic [BW-1:0] q_bcd,
  output logic          r_sign,
  output logic [BW-1:0] r_bcd
);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [MW-1:0] q_mag, r_mag, q_mag_nxt, r_mag_nxt, q_abs;
  logic [RW:0]   r_ext, r_abs;
  logic [BW-1:0] q_scr, r_scr, q_scr_nxt, r_scr_nxt;
  logic          q_neg, r_neg, load, last;

  // One extra bit so the most negative operand yields its true magnitude.
  assign q_abs = q[QW-1] ? (~{q[QW-1], q} + MW'(1)) : {1'b0, q};
  assign r_ext = {r[RW-1], r};
  assign r_abs = r[RW-1] ? (~r_ext + (RW+1)'(1)) : r_ext;

  bcd_add3_shift u_q_lane (.bcd(q_scr), .mag(q_mag), .bcd_nxt(q_scr_nxt), .mag_nxt(q_mag_nxt));
  bcd_add3_shift u_r_lane (.bcd(r_scr), .mag(r_mag), .bcd_nxt(r_scr_nxt), .mag_nxt(r_mag_nxt));

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (start) begin
        load      = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: if (cnt == CW'(ITER)) begin
        last      = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      q_sign <= 1'b0;
      r_sign <= 1'b0;
      q_bcd  <= '0;
      r_bcd  <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      q_mag  <= '0;
      r_mag  <= '0;
      q_scr  <= '0;
      r_scr  <= '0;
      cnt    <= '0;
    end else begin
      done <= last;
      if (load) begin
        q_neg <= q[QW-1];
        r_neg <= r[RW-1];
        q_mag <= q_abs;
        r_mag <= MW'(r_abs);
        q_scr <= '0;
        r_scr <= '0;
        cnt   <= '0;
        busy  <= 1'b1;
      end else if (state == SHIFT) begin
        q_scr <= q_scr_nxt;
        r_scr <= r_scr_nxt;
        q_mag <= q_mag_nxt;
        r_mag <= r_mag_nxt;
        cnt   <= cnt + CW'(1);
      end
      // Last step publishes the lane outputs directly; a zero magnitude never reports negative.
      if (last) begin
        q_bcd  <= q_scr_nxt;
        r_bcd  <= r_scr_nxt;
        q_sign <= q_neg && (q_scr_nxt != '0);
        r_sign <= r_neg && (r_scr_nxt != '0);
        busy   <= 1'b0;
      end
    end
  end

endmodule
